// File: rtl/truth_table_checker_pkg.sv
// Shared widths and FSM encoding for the truth-table checker and its
// coverage tracker.
package truth_table_checker_pkg;

  localparam int VEC_W     = 5;
  localparam int TBL_DEPTH = 32;
  localparam int CNT_W     = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/truth_table_checker_cov_tracker.sv
// Coverage bitmap plus distinct-vector counter; a hit only counts the first
// time its index is seen since the last clear.
module tt_cov_tracker
  import truth_table_checker_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 hit,
  input  logic [VEC_W-1:0]     idx,
  output logic [TBL_DEPTH-1:0] cov,
  output logic [CNT_W-1:0]     cov_cnt,
  output logic                 all_covered
);

  logic [TBL_DEPTH-1:0] cov_q, cov_d;
  logic [CNT_W-1:0]     cov_cnt_q, cov_cnt_d;

  always_comb begin
    cov_d     = cov_q;
    cov_cnt_d = cov_cnt_q;
    if (clr) begin
      cov_d     = '0;
      cov_cnt_d = '0;
    end else if (hit && !cov_q[idx]) begin
      cov_d[idx] = 1'b1;
      cov_cnt_d  = cov_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cov_q     <= '0;
      cov_cnt_q <= '0;
    end else begin
      cov_q     <= cov_d;
      cov_cnt_q <= cov_cnt_d;
    end
  end

  assign cov         = cov_q;
  assign cov_cnt     = cov_cnt_q;
  assign all_covered = (cov_cnt_q == CNT_W'(TBL_DEPTH));

endmodule

// File: rtl/truth_table_checker.sv
// Captures the observed truth table of a 5-input combinational DUT, tracking
// coverage, y toggles, mismatches against EXPECTED and inconsistent repeats.
module truth_table_checker
  import truth_table_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 vec_valid,
  input  logic [VEC_W-1:0]     vec,
  input  logic                 y,
  output logic [TBL_DEPTH-1:0] table_out,
  output logic [CNT_W-1:0]     cov_cnt,
  output logic [CNT_W-1:0]     toggle_cnt,
  output logic                 mismatch,
  output logic [VEC_W-1:0]     first_err_idx,
  output logic                 inconsistent,
  output logic                 done,
  output logic                 pass
);

  state_e               state_q, state_d;
  logic [TBL_DEPTH-1:0] table_out_q, table_out_d;
  logic [CNT_W-1:0]     toggle_cnt_q, toggle_cnt_d;
  logic                 mismatch_q, mismatch_d;
  logic [VEC_W-1:0]     first_err_idx_q, first_err_idx_d;
  logic                 inconsistent_q, inconsistent_d;
  logic                 have_prev_q, have_prev_d;
  logic                 prev_y_q, prev_y_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;

  logic                 accept;
  logic                 last_hit;
  logic [TBL_DEPTH-1:0] cov;
  logic                 all_covered;

  // start beats a coincident sample
  assign accept   = (state_q == CAPTURE) && vec_valid && !start;
  assign last_hit = accept && !cov[vec] && (cov_cnt == CNT_W'(TBL_DEPTH - 1));

  tt_cov_tracker u_cov (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (start),
    .hit         (accept),
    .idx         (vec),
    .cov         (cov),
    .cov_cnt     (cov_cnt),
    .all_covered (all_covered)
  );

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = CAPTURE;
    end else begin
      case (state_q)
        CAPTURE: if (last_hit || all_covered) state_d = DONE;
        IDLE, DONE: state_d = state_q;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    table_out_d     = table_out_q;
    toggle_cnt_d    = toggle_cnt_q;
    mismatch_d      = mismatch_q;
    first_err_idx_d = first_err_idx_q;
    inconsistent_d  = inconsistent_q;
    have_prev_d     = have_prev_q;
    prev_y_d        = prev_y_q;
    if (start) begin
      table_out_d     = '0;
      toggle_cnt_d    = '0;
      mismatch_d      = 1'b0;
      first_err_idx_d = '0;
      inconsistent_d  = 1'b0;
      have_prev_d     = 1'b0;
      prev_y_d        = 1'b0;
    end else if (accept) begin
      table_out_d[vec] = y;
      if (cov[vec] && (table_out_q[vec] != y)) inconsistent_d = 1'b1;
      if (y != EXPECTED[vec]) begin
        mismatch_d = 1'b1;
        if (!mismatch_q) first_err_idx_d = vec;
      end
      if (have_prev_q && (prev_y_q != y) && (toggle_cnt_q != '1))
        toggle_cnt_d = toggle_cnt_q + CNT_W'(1);
      have_prev_d = 1'b1;
      prev_y_d    = y;
    end
    done_d = (state_d == DONE);
    pass_d = done_d && !mismatch_d && !inconsistent_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      table_out_q     <= '0;
      toggle_cnt_q    <= '0;
      mismatch_q      <= 1'b0;
      first_err_idx_q <= '0;
      inconsistent_q  <= 1'b0;
      have_prev_q     <= 1'b0;
      prev_y_q        <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      table_out_q     <= table_out_d;
      toggle_cnt_q    <= toggle_cnt_d;
      mismatch_q      <= mismatch_d;
      first_err_idx_q <= first_err_idx_d;
      inconsistent_q  <= inconsistent_d;
      have_prev_q     <= have_prev_d;
      prev_y_q        <= prev_y_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
    end
  end

  assign table_out     = table_out_q;
  assign toggle_cnt    = toggle_cnt_q;
  assign mismatch      = mismatch_q;
  assign first_err_idx = first_err_idx_q;
  assign inconsistent  = inconsistent_q;
  assign done          = done_q;
  assign pass          = pass_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Self-checking bench for truth_table_checker: table vectors, directed runs
// and random runs, all compared against a behavioural model of the checker.
module tb_truth_table_checker;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        vec_valid;
  logic [4:0]  vec;
  logic        y;
  logic [31:0] table_out;
  logic [5:0]  cov_cnt;
  logic [5:0]  toggle_cnt;
  logic        mismatch;
  logic [4:0]  first_err_idx;
  logic        inconsistent;
  logic        done;
  logic        pass;

  localparam logic [31:0] EXP = 32'hFFFF_0000;

  truth_table_checker #(.EXPECTED(EXP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .vec_valid     (vec_valid),
    .vec           (vec),
    .y             (y),
    .table_out     (table_out),
    .cov_cnt       (cov_cnt),
    .toggle_cnt    (toggle_cnt),
    .mismatch      (mismatch),
    .first_err_idx (first_err_idx),
    .inconsistent  (inconsistent),
    .done          (done),
    .pass          (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  // Behavioural model: the run as a set of observed vectors
  logic [31:0] expTbl;
  bit  mTbl [32];
  bit  mCov [32];
  int  mTog;
  bit  mMm;
  int  mFirst;
  bit  mInc;
  bit  mRun;
  bit  mFin;
  bit  mHave;
  bit  mPrev;

  function automatic int modelCovCount();
    int n = 0;
    for (int i = 0; i < 32; i++) n += mCov[i];
    return n;
  endfunction

  function automatic logic [31:0] modelTable();
    logic [31:0] t;
    for (int i = 0; i < 32; i++) t[i] = mTbl[i];
    return t;
  endfunction

  task automatic modelClear();
    for (int i = 0; i < 32; i++) begin
      mTbl[i] = 0;
      mCov[i] = 0;
    end
    mTog = 0; mMm = 0; mFirst = 0; mInc = 0; mHave = 0; mPrev = 0;
  endtask

  task automatic modelReset();
    modelClear();
    mRun = 0;
    mFin = 0;
  endtask

  task automatic modelStep(input bit st, input bit vv, input int v, input bit yy);
    if (st) begin
      modelClear();
      mRun = 1;
      mFin = 0;
    end else if (mRun && vv) begin
      if (mCov[v] && mTbl[v] != yy) mInc = 1;
      if (yy != expTbl[v]) begin
        if (!mMm) mFirst = v;
        mMm = 1;
      end
      if (mHave && yy != mPrev) mTog = (mTog + 1 > 63) ? 63 : mTog + 1;
      mHave = 1;
      mPrev = yy;
      mTbl[v] = yy;
      mCov[v] = 1;
      if (modelCovCount() == 32) begin
        mRun = 0;
        mFin = 1;
      end
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".table_out"},     table_out,     modelTable());
    checkVal({tag, ".cov_cnt"},       32'(cov_cnt),  32'(modelCovCount()));
    checkVal({tag, ".toggle_cnt"},    32'(toggle_cnt), 32'(mTog));
    checkVal({tag, ".mismatch"},      32'(mismatch), 32'(mMm));
    checkVal({tag, ".first_err_idx"}, 32'(first_err_idx), 32'(mFirst));
    checkVal({tag, ".inconsistent"},  32'(inconsistent), 32'(mInc));
    checkVal({tag, ".done"},          32'(done),     32'(mFin));
    checkVal({tag, ".pass"},          32'(pass),     32'(mFin && !mMm && !mInc));
  endtask

  // Drive one cycle of inputs at the falling edge, let the model see the
  // rising edge, then compare shortly after it
  task automatic applyStimulus(input string tag, input bit st, input bit vv,
                               input int v, input bit yy);
    @(negedge clk);
    start     = st;
    vec_valid = vv;
    vec       = 5'(v);
    y         = yy;
    @(posedge clk);
    modelStep(st, vv, v, yy);
    #1;
    checkOutput(tag);
  endtask

  typedef struct {
    bit   st;
    bit   vv;
    int   v;
    bit   yy;
    int   expCov;
    int   expTog;
    bit   expMm;
    bit   expInc;
  } vec_rec_t;

  vec_rec_t recs [8];

  logic [31:0] snapTbl;
  logic [5:0]  snapCov, snapTog;
  logic [4:0]  snapFirst;
  logic        snapMm, snapInc, snapDone, snapPass;

  initial begin
    expTbl    = EXP;
    rst_n     = 1'b0;
    start     = 1'b0;
    vec_valid = 1'b0;
    vec       = '0;
    y         = 1'b0;
    modelReset();

    recs[0] = '{1, 0,  0, 0, 0, 0, 0, 0};
    recs[1] = '{0, 1,  0, 0, 1, 0, 0, 0};
    recs[2] = '{0, 1,  1, 1, 2, 1, 1, 0};
    recs[3] = '{0, 1,  1, 1, 2, 1, 1, 0};
    recs[4] = '{0, 1,  1, 0, 2, 2, 1, 1};
    recs[5] = '{0, 1, 20, 1, 3, 3, 1, 1};
    recs[6] = '{1, 1,  2, 0, 0, 0, 0, 0};
    recs[7] = '{0, 1,  2, 0, 1, 0, 0, 0};

    #12;
    checkOutput("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Samples before any start are ignored
    applyStimulus("idle", 0, 1, 7, 1);

    $display("[TB] table vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("tbl%0d", i), recs[i].st, recs[i].vv, recs[i].v, recs[i].yy);
      checkVal($sformatf("tbl%0d.cov", i), 32'(cov_cnt), 32'(recs[i].expCov));
      checkVal($sformatf("tbl%0d.tog", i), 32'(toggle_cnt), 32'(recs[i].expTog));
      checkVal($sformatf("tbl%0d.mm", i), 32'(mismatch), 32'(recs[i].expMm));
      checkVal($sformatf("tbl%0d.inc", i), 32'(inconsistent), 32'(recs[i].expInc));
    end

    $display("[TB] clean full run");
    applyStimulus("r030", 1, 0, 0, 0);
    for (int v = 0; v < 32; v++) begin
      applyStimulus("r030", 0, 1, v, v >= 16);
      if (v == 30) checkVal("r030.done_early", 32'(done), 32'd0);
    end
    checkVal("r030.done", 32'(done), 32'd1);
    checkVal("r030.pass", 32'(pass), 32'd1);
    checkVal("r030.table", table_out, 32'hFFFF_0000);
    checkVal("r030.tog", 32'(toggle_cnt), 32'd1);

    $display("[TB] mismatch run");
    applyStimulus("r031", 1, 0, 0, 0);
    for (int v = 0; v < 32; v++)
      applyStimulus("r031", 0, 1, v, (v >= 16) || v == 5 || v == 9);
    checkVal("r031.mm", 32'(mismatch), 32'd1);
    checkVal("r031.first", 32'(first_err_idx), 32'd5);
    checkVal("r031.pass", 32'(pass), 32'd0);
    checkVal("r031.cov", 32'(cov_cnt), 32'd32);

    $display("[TB] inconsistent run");
    applyStimulus("r032", 1, 0, 0, 0);
    for (int v = 0; v <= 10; v++) applyStimulus("r032", 0, 1, v, 0);
    applyStimulus("r032", 0, 1, 3, 0);
    checkVal("r032.inc_same", 32'(inconsistent), 32'd0);
    applyStimulus("r032", 0, 1, 3, 1);
    checkVal("r032.inc", 32'(inconsistent), 32'd1);
    checkVal("r032.cov_repeat", 32'(cov_cnt), 32'd11);
    for (int v = 11; v < 32; v++) applyStimulus("r032", 0, 1, v, v >= 16);
    checkVal("r032.done", 32'(done), 32'd1);
    checkVal("r032.pass", 32'(pass), 32'd0);

    $display("[TB] reset mid-run");
    applyStimulus("r034", 1, 0, 0, 0);
    for (int v = 0; v < 10; v++) applyStimulus("r034", 0, 1, v, 1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkVal("r034.table0", table_out, 32'd0);
    checkVal("r034.cov0", 32'(cov_cnt), 32'd0);
    checkVal("r034.tog0", 32'(toggle_cnt), 32'd0);
    checkVal("r034.mm0", 32'(mismatch), 32'd0);
    checkOutput("r034.async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int v = 0; v < 4; v++) applyStimulus("r034.ign", 0, 1, v, 1);
    checkVal("r034.ignored", 32'(cov_cnt), 32'd0);
    applyStimulus("r034.restart", 1, 0, 0, 0);
    applyStimulus("r034.restart", 0, 1, 17, 1);
    checkVal("r034.after", 32'(cov_cnt), 32'd1);

    $display("[TB] toggle saturation");
    applyStimulus("r035", 1, 0, 0, 0);
    for (int i = 0; i < 70; i++) applyStimulus("r035", 0, 1, i % 16, i % 2);
    checkVal("r035.tog", 32'(toggle_cnt), 32'd63);
    for (int v = 16; v < 32; v++) applyStimulus("r035", 0, 1, v, v % 2);
    checkVal("r035.done", 32'(done), 32'd1);
    snapTbl = table_out; snapCov = cov_cnt; snapTog = toggle_cnt;
    snapFirst = first_err_idx; snapMm = mismatch; snapInc = inconsistent;
    snapDone = done; snapPass = pass;
    for (int i = 0; i < 6; i++) applyStimulus("r035.hold", 0, 1, i * 5, ~i[0]);
    checkVal("r035.hold_tbl", table_out, snapTbl);
    checkVal("r035.hold_cov", 32'(cov_cnt), 32'(snapCov));
    checkVal("r035.hold_tog", 32'(toggle_cnt), 32'(snapTog));
    checkVal("r035.hold_flags",
             32'({first_err_idx, mismatch, inconsistent, done, pass}),
             32'({snapFirst, snapMm, snapInc, snapDone, snapPass}));

    $display("[TB] random runs");
    for (int r = 0; r < 3; r++) begin
      applyStimulus("rand", 1, 0, 0, 0);
      for (int k = 0; k < 3000 && !mFin; k++) begin
        int  v;
        bit  vv, st, yy;
        v  = $urandom_range(31);
        vv = ($urandom % 4) != 0;
        st = ($urandom % 300) == 0;
        yy = expTbl[v] ^ (($urandom % 12) == 0);
        applyStimulus("rand", st, vv, v, yy);
      end
      checkVal("rand.done", 32'(done), 32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/truth_table_checker.md
TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

Interface
REQ-001 Parameter: EXPECTED, 32'h0000_0000, expected 32-entry truth table; bit i is the required y for input vector i.
REQ-002 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  one-cycle pulse; clears all results and begins a capture run.
REQ-005 Port: vec_valid  input  1  vec/y pair is valid this cycle.
REQ-006 Port: vec  input  5  applied input vector {a,b,c,d,e}, a = MSB.
REQ-007 Port: y  input  1  DUT output observed for vec.
REQ-008 Port: table_out  output  32  captured truth table; bit vec holds the last y sampled for that vec.
REQ-009 Port: cov_cnt  output  6  number of distinct vectors captured in this run, 0..32.
REQ-010 Port: toggle_cnt  output  6  count of y changes between consecutive accepted samples, saturating at 63.
REQ-011 Port: mismatch  output  1  sticky; set when a sample has y != EXPECTED[vec].
REQ-012 Port: first_err_idx  output  5  vec of the first mismatching sample in this run.
REQ-013 Port: inconsistent  output  1  sticky; set when an already-covered vec is re-sampled with a different y.
REQ-014 Port: done  output  1  high while in DONE.
REQ-015 Port: pass  output  1  valid when done=1; equals !mismatch && !inconsistent.

Function
REQ-016 The FSM SHALL have states IDLE, CAPTURE and DONE.
- IDLE->CAPTURE on start.
- CAPTURE->DONE on the edge after the sample that raises cov_cnt to 32.
- DONE->CAPTURE on start.
REQ-017 start SHALL, in any state, clear table_out, the coverage bitmap, cov_cnt, toggle_cnt, mismatch, inconsistent, first_err_idx and the previous-y flag, then enter CAPTURE on the next edge.
REQ-018 A sample SHALL be accepted only when state=CAPTURE, vec_valid=1 and start=0; on the same-cycle collision start wins and the sample is dropped.
REQ-019 An accepted sample SHALL write table_out[vec]<=y and set cov[vec]; cov_cnt SHALL increment only if cov[vec] was previously 0.
REQ-020 An accepted sample with cov[vec]=1 and table_out[vec]!=y SHALL set inconsistent.
REQ-021 An accepted sample with y!=EXPECTED[vec] SHALL set mismatch; first_err_idx SHALL latch vec only if mismatch was 0 before that sample.
REQ-022 toggle_cnt SHALL increment when an accepted y differs from the previous accepted y; the first sample of a run never counts, and toggle_cnt holds at 63.
REQ-023 All outputs SHALL be registered and reflect a sample one cycle after acceptance; done SHALL rise one cycle after the 32nd distinct sample.
REQ-024 In IDLE and DONE, vec_valid SHALL be ignored and all outputs held.
REQ-025 pass SHALL read 0 whenever done=0.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE and all outputs and internal registers to 0, independent of clk.
REQ-027 Reset asserted mid-CAPTURE SHALL discard the run; after release, no sample is accepted until start.

Structure
REQ-028 A shared package SHALL hold VEC_W=5, TBL_DEPTH=32, CNT_W=6 and the state encoding (IDLE=2'd0, CAPTURE=2'd1, DONE=2'd2).
REQ-029 The coverage bitmap and cov_cnt logic SHALL be a sub-module tt_cov_tracker (inputs: clk, rst_n, clr, hit, idx; outputs: cov, cov_cnt, all_covered).

Verification
REQ-030 EXPECTED=32'hFFFF_0000; start, then vec=0..31 with y=vec[4] -> done=1 after 32 samples, pass=1, table_out=32'hFFFF_0000, toggle_cnt=1.
REQ-031 Same run with y forced to 1 at vec=5 and vec=9 -> mismatch=1, first_err_idx=5, pass=0, cov_cnt=32.
REQ-032 Re-send vec=3 with y=0 and then y=1 mid-run -> inconsistent=1, cov_cnt unchanged by the repeat, pass=0 at done.
REQ-033 Assert start together with vec_valid in CAPTURE -> that sample is not captured, cov_cnt=0 on the next cycle.
REQ-034 Drop rst_n between clock edges after 10 samples -> all outputs 0 immediately; samples after release are ignored until start.
REQ-035 Alternate y on 70 samples that revisit vectors -> toggle_cnt saturates at 63; vec_valid in DONE leaves all outputs unchanged.
